multicycle_ctrl: RTL and testbench

// Multi-cycle control FSM for the RV32I core: sequences one shared ALU and one unified

---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multi-cycle RV32I controller.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;
  // Memory handshake: mem_req is held until the cycle mem_ready is seen high.
  // mem_ready is meaningful only while mem_req is high and is otherwise ignored.
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        adr_src;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  imm_src;
  logic [1:0]  result_src;
  logic [2:0]  alu_ctrl;
  logic        fault;
  logic [3:0]  state_o;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, imm_src, result_src, alu_ctrl, fault, state_o
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, imm_src, result_src, alu_ctrl, fault, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences a shared ALU and unified memory
// through fetch/decode/execute/mem/writeback, with a memory-wait watchdog.
module multicycle_ctrl #(
  parameter int WDOG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALRADR  = 4'd11,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // A wait cycle seen while the counter already holds this value is the
  // (2**WDOG_W-1)-th consecutive one, so the access is abandoned.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((1 << WDOG_W) - 2);

  state_t            state, next;
  logic [WDOG_W-1:0] wdog;
  logic              mem_req_c;
  logic              waiting;
  logic              unused_instr_bits;

  wire [6:0] op     = bus.instr[6:0];
  wire [2:0] funct3 = bus.instr[14:12];
  wire       f7_5   = bus.instr[30];

  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  function automatic logic [2:0] alu_decode(input logic [6:0] opc,
                                            input logic [2:0] f3,
                                            input logic       f7);
    case (f3)
      3'b000:  alu_decode = (opc == OP_R && f7) ? 3'b001 : 3'b000;
      3'b010:  alu_decode = 3'b101;
      3'b110:  alu_decode = 3'b011;
      3'b111:  alu_decode = 3'b010;
      3'b001:  alu_decode = 3'b100;
      default: alu_decode = 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      wdog  <= '0;
    end else begin
      state <= next;
      if (next != state || !waiting) wdog <= '0;
      else                           wdog <= wdog + 1'b1;
    end
  end

  always_comb begin
    next           = state;
    mem_req_c      = 1'b0;
    waiting        = 1'b0;
    bus.mem_we     = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.imm_src    = 2'b00;
    bus.result_src = 2'b00;
    bus.alu_ctrl   = 3'b000;
    bus.fault      = 1'b0;
    // While rst is high every output is forced low, including FETCH's request.
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req_c      = 1'b1;
          bus.alu_src_b  = 2'b10;
          bus.result_src = 2'b10;
          bus.ir_write   = bus.mem_ready;
          bus.pc_write   = bus.mem_ready;
          if (bus.mem_ready) next = S_DECODE;
        end
        S_DECODE: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b01;
          if (op == OP_BR)       bus.imm_src = 2'b10;
          else if (op == OP_JAL) bus.imm_src = 2'b11;
          case (op)
            OP_LOAD, OP_STORE: next = S_MEMADR;
            OP_R:              next = S_EXECR;
            OP_I:              next = S_EXECI;
            OP_BR:             next = S_BRANCH;
            OP_JAL:            next = S_JAL;
            OP_JALR:           next = S_JALRADR;
            default:           next = S_FAULT;
          endcase
        end
        S_MEMADR: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
          bus.imm_src   = (op == OP_STORE) ? 2'b01 : 2'b00;
          next          = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          mem_req_c   = 1'b1;
          bus.adr_src = 1'b1;
          if (bus.mem_ready) next = S_MEMWB;
        end
        S_MEMWB: begin
          bus.result_src = 2'b01;
          bus.reg_write  = 1'b1;
          next           = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req_c   = 1'b1;
          bus.mem_we  = 1'b1;
          bus.adr_src = 1'b1;
          if (bus.mem_ready) next = S_FETCH;
        end
        S_EXECR: begin
          bus.alu_src_a = 2'b10;
          bus.alu_ctrl  = alu_decode(op, funct3, f7_5);
          next          = S_ALUWB;
        end
        S_EXECI: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
          bus.alu_ctrl  = alu_decode(op, funct3, f7_5);
          next          = S_ALUWB;
        end
        S_ALUWB: begin
          bus.reg_write = 1'b1;
          next          = S_FETCH;
        end
        S_BRANCH: begin
          bus.alu_src_a = 2'b10;
          bus.alu_ctrl  = 3'b001;
          if (funct3 == 3'b000)      bus.pc_write = bus.zero;
          else if (funct3 == 3'b001) bus.pc_write = !bus.zero;
          next = S_FETCH;
        end
        S_JAL: begin
          // PC <= ALUOut (target) while the ALU forms oldPC+4 for ALUWB.
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
          bus.pc_write  = 1'b1;
          next          = S_ALUWB;
        end
        S_JALRADR: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
          next          = S_JAL;
        end
        S_FAULT: bus.fault = 1'b1;
        default: next = S_FAULT;
      endcase
      waiting = mem_req_c & ~bus.mem_ready;
      if (waiting && wdog == WDOG_LAST) next = S_FAULT;
    end
  end

  assign bus.mem_req = mem_req_c;
  assign bus.state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: state sequences, decode
// outputs, branch resolution, fault/watchdog and asynchronous reset.
module tb_multicycle_ctrl;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.WDOG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // Leaves the bench at a falling edge with rst low and the DUT in FETCH.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.instr = 32'h0000_007F;
    bus.zero = 1'b1;
    @(negedge clk);
    #1;
    n_total++;
    if ({bus.mem_req, bus.ir_write, bus.pc_write, bus.reg_write, bus.fault} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000",
               {bus.mem_req, bus.ir_write, bus.pc_write, bus.reg_write, bus.fault});
    else n_pass++;
    n_total++;
    if ({bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_ctrl} !== 9'b0)
      $display("FAIL reset_muxes: got %b want 0",
               {bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_ctrl});
    else n_pass++;
    n_total++;
    if (bus.state_o !== 4'd0) $display("FAIL reset_state: got %0d want 0", bus.state_o);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.mem_req !== 1'b1) $display("FAIL reset_release_req: got %b want 1", bus.mem_req);
    else n_pass++;
  endtask

  // addi x1,x0,5 with zero-wait memory: FETCH, DECODE, EXECI, ALUWB, FETCH.
  task automatic test_addi();
    int exp_s [5] = '{0, 1, 7, 8, 0};
    do_reset();
    bus.instr = 32'h0050_0093;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (bus.state_o !== 4'(exp_s[i])) $display("FAIL addi_state[%0d]: got %0d want %0d", i, bus.state_o, exp_s[i]);
      else n_pass++;
      n_total++;
      if (bus.reg_write !== (exp_s[i] == 8)) $display("FAIL addi_reg_write[%0d]: got %b want %b", i, bus.reg_write, exp_s[i] == 8);
      else n_pass++;
      if (i == 0) begin
        n_total++;
        if ({bus.mem_req, bus.ir_write, bus.pc_write, bus.alu_src_b, bus.result_src} !== 7'b1111010)
          $display("FAIL addi_fetch: got %b want 1111010",
                   {bus.mem_req, bus.ir_write, bus.pc_write, bus.alu_src_b, bus.result_src});
        else n_pass++;
      end
      if (i == 2) begin
        n_total++;
        if ({bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_ctrl} !== 9'b10_01_00_000)
          $display("FAIL addi_execi: got %b want 100100000",
                   {bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_ctrl});
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  // ALU decode in EXECR/EXECI for several funct3/funct7 patterns.
  task automatic test_alu_decode();
    logic [31:0] ins  [8] = '{32'h4020_8133, 32'h0020_8133, 32'h0020_E133, 32'h0020_F133,
                              32'h0020_A133, 32'h0020_9133, 32'h0020_D133, 32'h4000_0093};
    logic [2:0]  exp  [8] = '{3'b001, 3'b000, 3'b011, 3'b010, 3'b101, 3'b100, 3'b000, 3'b000};
    int          st   [8] = '{6, 6, 6, 6, 6, 6, 6, 7};
    for (int k = 0; k < 8; k++) begin
      do_reset();
      bus.instr = ins[k];
      bus.mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_total++;
      if (bus.state_o !== 4'(st[k]) || bus.alu_ctrl !== exp[k])
        $display("FAIL alu_decode[%0d]: got state %0d ctrl %b want state %0d ctrl %b",
                 k, bus.state_o, bus.alu_ctrl, st[k], exp[k]);
      else n_pass++;
    end
  endtask

  // lw with three wait cycles in MEMREAD.
  task automatic test_load_wait();
    int   exp_s [9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    logic rdy   [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    do_reset();
    bus.instr = 32'h0000_A083;
    for (int i = 0; i < 9; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      n_total++;
      if (bus.state_o !== 4'(exp_s[i])) $display("FAIL load_state[%0d]: got %0d want %0d", i, bus.state_o, exp_s[i]);
      else n_pass++;
      if (exp_s[i] == 3) begin
        n_total++;
        if ({bus.mem_req, bus.adr_src, bus.mem_we} !== 3'b110)
          $display("FAIL load_memread[%0d]: got %b want 110", i, {bus.mem_req, bus.adr_src, bus.mem_we});
        else n_pass++;
      end
      if (exp_s[i] == 4) begin
        n_total++;
        if ({bus.result_src, bus.reg_write} !== 3'b011)
          $display("FAIL load_memwb: got %b want 011", {bus.result_src, bus.reg_write});
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  // beq/bne resolution from zero, plus an unsupported funct3 (never taken).
  task automatic test_branch();
    logic [31:0] ins [4] = '{32'h0020_8063, 32'h0020_9063, 32'h0020_9063, 32'h0020_C063};
    logic        z   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        pw  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      bus.instr = ins[k];
      bus.zero = z[k];
      bus.mem_ready = 1'b1;
      @(negedge clk);
      #1;
      n_total++;
      if (bus.state_o !== 4'd1 || bus.imm_src !== 2'b10)
        $display("FAIL branch_decode[%0d]: got state %0d imm %b want state 1 imm 10", k, bus.state_o, bus.imm_src);
      else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if (bus.state_o !== 4'd9 || bus.pc_write !== pw[k] || bus.alu_ctrl !== 3'b001)
        $display("FAIL branch_exec[%0d]: got state %0d pc_write %b ctrl %b want state 9 pc_write %b ctrl 001",
                 k, bus.state_o, bus.pc_write, bus.alu_ctrl, pw[k]);
      else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if (bus.state_o !== 4'd0) $display("FAIL branch_return[%0d]: got %0d want 0", k, bus.state_o);
      else n_pass++;
    end
    bus.zero = 1'b0;
  endtask

  // jal: 0,1,10,8,0 and jalr: 0,1,11,10,8,0.
  task automatic test_jumps();
    int exp_jal  [5] = '{0, 1, 10, 8, 0};
    int exp_jalr [6] = '{0, 1, 11, 10, 8, 0};
    do_reset();
    bus.instr = 32'h0080_00EF;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (bus.state_o !== 4'(exp_jal[i])) $display("FAIL jal_state[%0d]: got %0d want %0d", i, bus.state_o, exp_jal[i]);
      else n_pass++;
      if (i == 1) begin
        n_total++;
        if (bus.imm_src !== 2'b11) $display("FAIL jal_imm_src: got %b want 11", bus.imm_src);
        else n_pass++;
      end
      @(negedge clk);
    end
    do_reset();
    bus.instr = 32'h0000_80E7;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_total++;
      if (bus.state_o !== 4'(exp_jalr[i])) $display("FAIL jalr_state[%0d]: got %0d want %0d", i, bus.state_o, exp_jalr[i]);
      else n_pass++;
      if (exp_jalr[i] == 10) begin
        n_total++;
        if ({bus.pc_write, bus.alu_src_a, bus.alu_src_b} !== 5'b1_01_10)
          $display("FAIL jalr_jal_state: got %b want 10110", {bus.pc_write, bus.alu_src_a, bus.alu_src_b});
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  // Illegal opcode enters FAULT and stays there regardless of mem_ready.
  task automatic test_illegal();
    do_reset();
    bus.instr = 32'h0000_007F;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      n_total++;
      if ({bus.state_o, bus.fault, bus.mem_req, bus.pc_write, bus.reg_write} !== 8'b1111_1000)
        $display("FAIL illegal_hold[%0d]: got %b want 11111000", i,
                 {bus.state_o, bus.fault, bus.mem_req, bus.pc_write, bus.reg_write});
      else n_pass++;
      @(negedge clk);
    end
  endtask

  // 15 consecutive wait cycles in FETCH abandon the access; ready on the 15th wins.
  task automatic test_watchdog();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      bus.instr = 32'h0050_0093;
      for (int i = 0; i < 15; i++) begin
        bus.mem_ready = (k == 1 && i == 14);
        #1;
        n_total++;
        if (bus.state_o !== 4'd0 || bus.mem_req !== 1'b1)
          $display("FAIL wdog_wait[%0d.%0d]: got state %0d req %b want state 0 req 1", k, i, bus.state_o, bus.mem_req);
        else n_pass++;
        @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      #1;
      n_total++;
      if (k == 0 && (bus.state_o !== 4'd15 || bus.fault !== 1'b1))
        $display("FAIL wdog_timeout: got state %0d fault %b want state 15 fault 1", bus.state_o, bus.fault);
      else if (k == 1 && (bus.state_o !== 4'd1 || bus.fault !== 1'b0))
        $display("FAIL wdog_ready_wins: got state %0d fault %b want state 1 fault 0", bus.state_o, bus.fault);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  // sw reaches MEMWRITE; an asynchronous reset mid-cycle drops the request at once.
  task automatic test_store_reset();
    do_reset();
    bus.instr = 32'h0020_A023;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_total++;
    if (bus.state_o !== 4'd2 || bus.imm_src !== 2'b01 || bus.alu_src_a !== 2'b10)
      $display("FAIL store_memadr: got state %0d imm %b a %b want state 2 imm 01 a 10",
               bus.state_o, bus.imm_src, bus.alu_src_a);
    else n_pass++;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    n_total++;
    if ({bus.state_o, bus.mem_req, bus.mem_we, bus.adr_src} !== 7'b0101_111)
      $display("FAIL store_memwrite: got %b want 0101111", {bus.state_o, bus.mem_req, bus.mem_we, bus.adr_src});
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if ({bus.state_o, bus.mem_req, bus.mem_we, bus.fault} !== 7'b0000_000)
      $display("FAIL store_async_reset: got %b want 0000000", {bus.state_o, bus.mem_req, bus.mem_we, bus.fault});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // addi then sw (zero wait) then add with no reset between instructions.
  task automatic test_back_to_back();
    logic [31:0] ins   [13] = '{32'h0050_0093, 32'h0050_0093, 32'h0050_0093, 32'h0050_0093,
                                32'h0020_A023, 32'h0020_A023, 32'h0020_A023, 32'h0020_A023,
                                32'h0020_8133, 32'h0020_8133, 32'h0020_8133, 32'h0020_8133,
                                32'h0020_8133};
    int          exp_s [13] = '{0, 1, 7, 8, 0, 1, 2, 5, 0, 1, 6, 8, 0};
    do_reset();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus.instr = ins[i];
      #1;
      n_total++;
      if (bus.state_o !== 4'(exp_s[i])) $display("FAIL b2b_state[%0d]: got %0d want %0d", i, bus.state_o, exp_s[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    bus.instr = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_addi();
    test_alu_decode();
    test_load_wait();
    test_branch();
    test_jumps();
    test_illegal();
    test_watchdog();
    test_store_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
